// File: rtl/comm_pkg.sv
// Shared definitions for the serial receive path: FSM encodings, default word width, parity helper.
package comm_pkg;

    localparam int DEFAULT_WORD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } rx_state_e;

    // Even parity: returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_word_rx_if.sv
// Handshake bundle between the serial source/word consumer and serial_word_rx.
// slave = receiver side, master = source/consumer side.
interface serial_word_rx_if #(
    parameter int WORD_W = comm_pkg::DEFAULT_WORD_W
);
    logic              ser_in;
    logic              ser_vld;
    logic              frame_start;
    logic [WORD_W-1:0] dout;
    logic              dout_vld;
    logic              dout_rdy;
    logic              frame_err;
    logic              ovr_err;
    logic              parity_err;
    logic              err_clr;

    modport master (
        output ser_in, ser_vld, frame_start, dout_rdy, err_clr,
        input  dout, dout_vld, frame_err, ovr_err, parity_err
    );

    modport slave (
        input  ser_in, ser_vld, frame_start, dout_rdy, err_clr,
        output dout, dout_vld, frame_err, ovr_err, parity_err
    );
endinterface

// File: rtl/serial_shift_reg.sv
// WORD_W-bit shift register with clear and load-enable; LSB_FIRST sets which end the first bit lands in.
// word_o is the next-state value so the caller can capture a word on the same edge its last bit is shifted in.
module serial_shift_reg #(
    parameter int WORD_W    = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] word_o
);
    logic [WORD_W-1:0] sr_q;
    logic [WORD_W-1:0] sr_d;
    logic [WORD_W-1:0] base;

    always_comb begin
        base = clr_i ? '0 : sr_q;
        sr_d = base;
        if (en_i) begin
            // After WORD_W shifts the first bit sits at [0] (LSB_FIRST) or [WORD_W-1].
            sr_d = LSB_FIRST ? {bit_i, base[WORD_W-1:1]} : {base[WORD_W-2:0], bit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign word_o = sr_d;
endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel receiver: frames WORD_W bits per frame_start, one-entry valid/ready output, sticky errors.
// Build option PARITY_CHECK_EN appends an even-parity bit to every frame and enables parity_err.
module serial_word_rx
    import comm_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    serial_word_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              dout_vld_q, dout_vld_d;
    logic              frame_err_q, frame_err_d;
    logic              ovr_err_q, ovr_err_d;

    logic              sr_clr;
    logic              sr_en;
    logic [WORD_W-1:0] sr_word;
    logic              complete;
    logic              frame_set;
    logic              ovr_set;
`ifdef PARITY_CHECK_EN
    logic              parity_err_q, parity_err_d;
    logic              parity_set;
`endif

    serial_shift_reg #(
        .WORD_W    (WORD_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (sr_clr),
        .en_i   (sr_en),
        .bit_i  (bus.ser_in),
        .word_o (sr_word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_clr    = 1'b0;
        sr_en     = 1'b0;
        complete  = 1'b0;
        frame_set = 1'b0;
`ifdef PARITY_CHECK_EN
        parity_set = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.ser_vld && bus.frame_start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_W'(1);
                    sr_clr  = 1'b1;
                    sr_en   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (bus.ser_vld) begin
                    sr_en = 1'b1;
                    if (bus.frame_start) begin
                        frame_set = 1'b1;
                        sr_clr    = 1'b1;
                        cnt_d     = CNT_W'(1);
                    end else if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_d = ST_PARITY;
                        cnt_d   = CNT_W'(WORD_W);
`else
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                        complete = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            ST_PARITY: begin
                // Shift register is not enabled here, so sr_word is the held data word.
                if (bus.ser_vld) begin
                    if (bus.frame_start) begin
                        frame_set = 1'b1;
                        state_d   = ST_SHIFT;
                        cnt_d     = CNT_W'(1);
                        sr_clr    = 1'b1;
                        sr_en     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        if (even_parity(64'(sr_word)) == bus.ser_in) begin
                            complete = 1'b1;
                        end else begin
                            parity_set = 1'b1;
                        end
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        ovr_set    = 1'b0;
        if (complete) begin
            // A word may replace one being accepted in the same cycle.
            if (!dout_vld_q || bus.dout_rdy) begin
                dout_d     = sr_word;
                dout_vld_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (bus.dout_rdy) begin
            dout_vld_d = 1'b0;
        end
        // A new error in the clearing cycle wins over err_clr.
        frame_err_d = (frame_err_q && !bus.err_clr) || frame_set;
        ovr_err_d   = (ovr_err_q && !bus.err_clr) || ovr_set;
`ifdef PARITY_CHECK_EN
        parity_err_d = (parity_err_q && !bus.err_clr) || parity_set;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            frame_err_q <= frame_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = dout_vld_q;
    assign bus.frame_err = frame_err_q;
    assign bus.ovr_err   = ovr_err_q;
endmodule
